// File: rtl/urv_regfile_mp.sv
// Multi-read-port register file for the uRV pipeline.
// Parametrised in width, depth and read-port count, with a clear sequencer
// that zeroes the whole array after reset or on request, a write-through
// register for read-during-write, and a writeback-to-execute bypass.
module urv_regfile_mp #(
    parameter int g_width     = 32,
    parameter int g_addr_bits = 5,
    parameter int g_num_read  = 2,
    parameter int g_zero_reg  = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    output logic                              init_busy_o,
    input  logic                              d_stall_i,
    input  logic [g_num_read*g_addr_bits-1:0] rf_rs_i,
    input  logic [g_num_read*g_addr_bits-1:0] d_rs_i,
    output logic [g_num_read*g_width-1:0]     x_rs_value_o,
    input  logic [g_addr_bits-1:0]            w_rd_i,
    input  logic [g_width-1:0]                w_rd_value_i,
    input  logic                              w_rd_store_i,
    input  logic                              w_bypass_rd_write_i,
    input  logic [g_width-1:0]                w_bypass_rd_value_i
);

    localparam int DEPTH = 1 << g_addr_bits;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [g_addr_bits-1:0] clr_ptr, clr_ptr_nxt;
    logic                   idle;
    logic                   wr_ok;

    logic [g_width-1:0]                      mem [DEPTH];
    logic [g_num_read-1:0][g_width-1:0]      rd_val;
    logic [g_num_read-1:0]                   rsw;
    logic [g_width-1:0]                      bypass_w;

    assign idle        = (state == ST_IDLE);
    assign init_busy_o = (state == ST_CLEAR);

    // A write only counts outside the clear sequence and never targets a hardwired x0.
    assign wr_ok = idle && w_rd_store_i && !((g_zero_reg != 0) && (w_rd_i == '0));

    // Clear sequencer state and pointer; reset restarts the full sweep.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // Next-state: IDLE waits for a clear request, CLEAR walks every address once.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            ST_IDLE: begin
                if (clear_i) begin
                    state_nxt   = ST_CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            ST_CLEAR: begin
                clr_ptr_nxt = clr_ptr + {{(g_addr_bits-1){1'b0}}, 1'b1};
                if (&clr_ptr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_ptr_nxt = '0;
            end
        endcase
    end

    // Array write port: the sequencer owns it while clearing, writeback otherwise.
    always_ff @(posedge clk_i) begin
        if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_ok) begin
            mem[w_rd_i] <= w_rd_value_i;
        end
    end

    // Copy of the latest committed write, returned when a read raced that write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bypass_w <= '0;
        end else if (wr_ok) begin
            bypass_w <= w_rd_value_i;
        end
    end

    // Per-port read registers and read-during-write flags; forced to zero while clearing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_val <= '0;
            rsw    <= '0;
        end else if (!idle) begin
            rd_val <= '0;
            rsw    <= '0;
        end else if (!d_stall_i) begin
            for (int k = 0; k < g_num_read; k++) begin
                rd_val[k] <= mem[rf_rs_i[k*g_addr_bits +: g_addr_bits]];
                rsw[k]    <= wr_ok && (rf_rs_i[k*g_addr_bits +: g_addr_bits] == w_rd_i);
            end
        end
    end

    // Operand mux per port: writeback bypass first, then write-through, then array data.
    always_comb begin
        x_rs_value_o = '0;
        for (int k = 0; k < g_num_read; k++) begin
            if (idle && w_bypass_rd_write_i &&
                (d_rs_i[k*g_addr_bits +: g_addr_bits] == w_rd_i) && (w_rd_i != '0)) begin
                x_rs_value_o[k*g_width +: g_width] = w_bypass_rd_value_i;
            end else if (rsw[k]) begin
                x_rs_value_o[k*g_width +: g_width] = bypass_w;
            end else begin
                x_rs_value_o[k*g_width +: g_width] = rd_val[k];
            end
        end
    end

endmodule

// File: tb/tb_urv_regfile_mp.sv
// Bench for urv_regfile_mp: two instances (x0 hardwired / x0 writable) share
// all inputs; a reference model tracks architectural state and every
// negative clock edge the outputs of both instances are compared against it.
module tb_urv_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        stall = 1'b0;
    logic [9:0]  rf_rs = '0;
    logic [9:0]  d_rs = '0;
    logic [4:0]  w_rd = '0;
    logic [31:0] w_val = '0;
    logic        w_store = 1'b0;
    logic        bp_wr = 1'b0;
    logic [31:0] bp_val = '0;

    logic        busy_zr, busy_nz;
    logic [63:0] out_zr, out_nz;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    urv_regfile_mp #(.g_width(32), .g_addr_bits(5), .g_num_read(2), .g_zero_reg(1)) u_zr (
        .clk_i(clk), .rst_i(rst_n), .clear_i(clear), .init_busy_o(busy_zr),
        .d_stall_i(stall), .rf_rs_i(rf_rs), .d_rs_i(d_rs), .x_rs_value_o(out_zr),
        .w_rd_i(w_rd), .w_rd_value_i(w_val), .w_rd_store_i(w_store),
        .w_bypass_rd_write_i(bp_wr), .w_bypass_rd_value_i(bp_val)
    );

    urv_regfile_mp #(.g_width(32), .g_addr_bits(5), .g_num_read(2), .g_zero_reg(0)) u_nz (
        .clk_i(clk), .rst_i(rst_n), .clear_i(clear), .init_busy_o(busy_nz),
        .d_stall_i(stall), .rf_rs_i(rf_rs), .d_rs_i(d_rs), .x_rs_value_o(out_nz),
        .w_rd_i(w_rd), .w_rd_value_i(w_val), .w_rd_store_i(w_store),
        .w_bypass_rd_write_i(bp_wr), .w_bypass_rd_value_i(bp_val)
    );

    // Reference model: index 0 = x0 hardwired, index 1 = x0 writable.
    logic [31:0] m_arr [2][32];
    logic [31:0] m_rd  [2][2];
    logic        m_rsw [2][2];
    logic [31:0] m_bw  [2];
    logic        m_busy;
    int          m_left;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] dut_out(input int d, input int k);
        return (d == 0) ? out_zr[k*32 +: 32] : out_nz[k*32 +: 32];
    endfunction

    function automatic logic [31:0] exp_out(input int d, input int k);
        if (!m_busy && bp_wr && d_rs[k*5 +: 5] == w_rd && w_rd != 5'd0) return bp_val;
        if (m_rsw[d][k]) return m_bw[d];
        return m_rd[d][k];
    endfunction

    function automatic void model_reset();
        m_busy = 1'b1;
        m_left = 32;
        for (int d = 0; d < 2; d++) begin
            m_bw[d] = '0;
            for (int a = 0; a < 32; a++) m_arr[d][a] = '0;
            for (int k = 0; k < 2; k++) begin
                m_rd[d][k]  = '0;
                m_rsw[d][k] = 1'b0;
            end
        end
    endfunction

    // Model update at each clock edge (inputs are stable there) and on reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    logic q;
                    q = !m_busy && w_store && !(d == 0 && w_rd == 5'd0);
                    for (int k = 0; k < 2; k++) begin
                        if (m_busy) begin
                            m_rd[d][k]  = '0;
                            m_rsw[d][k] = 1'b0;
                        end else if (!stall) begin
                            m_rd[d][k]  = m_arr[d][rf_rs[k*5 +: 5]];
                            m_rsw[d][k] = q && (rf_rs[k*5 +: 5] == w_rd);
                        end
                    end
                    if (q) begin
                        m_arr[d][w_rd] = w_val;
                        m_bw[d]        = w_val;
                    end
                end
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) m_busy = 1'b0;
                end else if (clear) begin
                    m_busy = 1'b1;
                    m_left = 32;
                    for (int d = 0; d < 2; d++)
                        for (int a = 0; a < 32; a++) m_arr[d][a] = '0;
                end
            end
        end
    end

    // Continuous comparison against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++)
                    for (int k = 0; k < 2; k++)
                        chk($sformatf("model_d%0d_p%0d", d, k), dut_out(d, k), exp_out(d, k));
                chk("model_busy_zr", {31'd0, busy_zr}, {31'd0, m_busy});
                chk("model_busy_nz", {31'd0, busy_nz}, {31'd0, m_busy});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        w_rd = a; w_val = v; w_store = 1'b1;
        tick();
        w_store = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_zr) break;
            n++;
            tick();
            w_store = 1'b0;
        end
        chk(name, n, 32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        #1;
        chk("reset_out_zr", out_zr[31:0], 32'h0);
        chk("reset_out_nz", out_nz[63:32], 32'h0);
        chk("reset_busy", {31'd0, busy_zr}, 32'd1);

        // Release reset and measure the clear sweep.
        rst_n = 1'b1;
        count_busy("init_busy_len");

        // Every address reads zero on every port after the sweep.
        for (int a = 0; a < 32; a++) begin
            rf_rs = {5'(31 - a), 5'(a)};
            tick();
        end
        chk("post_clear_p0", out_zr[31:0], 32'h0);
        chk("post_clear_p1", out_nz[63:32], 32'h0);

        // Read-during-write returns the new value through the write-through path.
        rf_rs = {5'd0, 5'd5};
        wr(5'd5, 32'hDEADBEEF);
        #1;
        chk("rdw_bypass_p0", out_zr[31:0], 32'hDEADBEEF);
        tick();
        #1;
        chk("rdw_array_p0", out_zr[31:0], 32'hDEADBEEF);

        // Writeback bypass to execute, and its suppression for x0.
        wr(5'd7, 32'h00000001);
        rf_rs = {5'd7, 5'd5};
        tick();
        d_rs = {5'd7, 5'd5};
        bp_wr = 1'b1; w_rd = 5'd7; bp_val = 32'h12345678;
        #1;
        chk("xbyp_p1", out_zr[63:32], 32'h12345678);
        chk("xbyp_p0_unaffected", out_zr[31:0], 32'hDEADBEEF);
        w_rd = 5'd0;
        #1;
        chk("xbyp_x0_p1", out_zr[63:32], 32'h00000001);
        tick();
        bp_wr = 1'b0;

        // x0 hardwired versus writable.
        wr(5'd0, 32'hFFFFFFFF);
        rf_rs = {5'd0, 5'd0};
        d_rs = {5'd0, 5'd0};
        tick();
        tick();
        #1;
        chk("x0_zr", out_zr[31:0], 32'h0);
        chk("x0_nz", out_nz[31:0], 32'hFFFFFFFF);

        // Stall holds the read register across an address change.
        wr(5'd3, 32'h33333333);
        wr(5'd4, 32'h44444444);
        rf_rs = {5'd4, 5'd3};
        tick();
        #1;
        chk("stall_before", out_zr[31:0], 32'h33333333);
        stall = 1'b1;
        rf_rs = {5'd3, 5'd4};
        tick();
        tick();
        #1;
        chk("stall_hold_p0", out_zr[31:0], 32'h33333333);
        chk("stall_hold_p1", out_zr[63:32], 32'h44444444);
        stall = 1'b0;
        tick();
        #1;
        chk("stall_release_p0", out_zr[31:0], 32'h44444444);

        // Requested clear wipes prior contents and drops writes made while busy.
        wr(5'd9, 32'hA5A5A5A5);
        rf_rs = {5'd9, 5'd9};
        tick();
        #1;
        chk("pre_clear_x9", out_nz[31:0], 32'hA5A5A5A5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        w_rd = 5'd10; w_val = 32'h1; w_store = 1'b1;
        count_busy("clear_busy_len");
        rf_rs = {5'd10, 5'd9};
        tick();
        #1;
        chk("clear_x9", out_zr[31:0], 32'h0);
        chk("clear_x10", out_nz[63:32], 32'h0);

        // Reset in the middle of a sweep restarts the full sequence.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_busy("reclear_busy_len");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
